// File: rtl/character_action_fsm_if.sv
// character_action_fsm_if: frame tick, key levels and hurt event in; sprite position, state and events out.
interface character_action_fsm_if;
    logic       frame_tick, enable, restart;
    logic       move_l, move_r, attack, defense, hurt;
    logic [9:0] pos_x;
    logic       facing;
    logic [2:0] state, anim_frame;
    logic       hit_pulse, damage_pulse, blocked_pulse;
    modport master (
        output frame_tick, enable, restart, move_l, move_r, attack, defense, hurt,
        input  pos_x, facing, state, anim_frame, hit_pulse, damage_pulse, blocked_pulse
    );
    modport slave (
        input  frame_tick, enable, restart, move_l, move_r, attack, defense, hurt,
        output pos_x, facing, state, anim_frame, hit_pulse, damage_pulse, blocked_pulse
    );
endinterface

// File: rtl/character_action_fsm.sv
// character_action_fsm: per-character action/motion controller, stepped once per enabled frame tick.
// Define CHARACTER_ACTION_KEY_SYNC_EN to pass the four key levels through a two-flop synchronizer.
module character_action_fsm #(
    parameter logic [9:0] X_INIT          = 10'd120,
    parameter logic [9:0] X_MIN           = 10'd0,
    parameter logic [9:0] X_MAX           = 10'd575,
    parameter logic [9:0] STEP            = 10'd4,
    parameter logic [5:0] ATTACK_FRAMES   = 6'd18,
    parameter logic [5:0] HIT_FRAME       = 6'd9,
    parameter logic [5:0] COOLDOWN_FRAMES = 6'd12,
    parameter logic [5:0] HURT_FRAMES     = 6'd15,
    parameter logic [3:0] ANIM_DIV        = 4'd6,
    parameter logic       FACE_INIT       = 1'b1
) (
    input logic Clk,
    input logic Reset,
    character_action_fsm_if.slave io
);
    typedef enum logic [2:0] {IDLE = 3'd0, WALK = 3'd1, ATTACK = 3'd2, DEFEND = 3'd3, HURT = 3'd4} state_t;
    typedef struct packed {
        logic [9:0] pos_x;
        logic       facing;
        logic [2:0] anim;
        logic [3:0] div;
        logic [5:0] cnt;
        logic [5:0] cool;
        logic       hurt_pend;
        logic       attack_prev;
        logic       hit;
        logic       dmg;
        logic       blk;
    } regs_t;
    localparam regs_t RST = '{pos_x: X_INIT, facing: FACE_INIT, anim: 3'd0, div: 4'd0, cnt: 6'd0,
                              cool: 6'd0, hurt_pend: 1'b0, attack_prev: 1'b0, hit: 1'b0, dmg: 1'b0, blk: 1'b0};

    state_t state_q, state_d;
    regs_t  regs_q, regs_d;
    logic   move_l, move_r, attack, defense;
    logic   tick, hurt_now, attack_rise, busy, last, hi_clamp, lo_clamp;

`ifdef CHARACTER_ACTION_KEY_SYNC_EN
    logic [3:0] sync1_q, sync2_q;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
        end else begin
            sync1_q <= {io.move_l, io.move_r, io.attack, io.defense};
            sync2_q <= sync1_q;
        end
    end
    assign {move_l, move_r, attack, defense} = sync2_q;
`else
    assign {move_l, move_r, attack, defense} = {io.move_l, io.move_r, io.attack, io.defense};
`endif

    // A hurt pulse on the tick cycle itself counts for that tick.
    assign tick        = io.frame_tick & io.enable;
    assign hurt_now    = regs_q.hurt_pend | io.hurt;
    assign attack_rise = attack & ~regs_q.attack_prev;
    assign busy        = (state_q == ATTACK) || (state_q == HURT);
    assign last        = regs_q.cnt == ((state_q == ATTACK) ? ATTACK_FRAMES : HURT_FRAMES) - 6'd1;
    assign hi_clamp    = {1'b0, regs_q.pos_x} + {1'b0, STEP} > {1'b0, X_MAX};
    assign lo_clamp    = {1'b0, regs_q.pos_x} < {1'b0, X_MIN} + {1'b0, STEP};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            regs_q  <= RST;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (io.restart) state_d = IDLE;
        else if (tick) begin
            if (hurt_now) state_d = (state_q == DEFEND) ? DEFEND : HURT;
            else if (busy) state_d = last ? IDLE : state_q;
            else if (attack_rise && regs_q.cool == 6'd0) state_d = ATTACK;
            else if (defense) state_d = DEFEND;
            else state_d = (move_l ^ move_r) ? WALK : IDLE;
        end
    end

    // Cooldown only drains while the character is free to act.
    always_comb begin
        regs_d = regs_q;
        regs_d.hurt_pend = hurt_now;
        regs_d.hit = 1'b0;
        regs_d.dmg = 1'b0;
        regs_d.blk = 1'b0;
        if (tick) begin
            regs_d.hurt_pend   = 1'b0;
            regs_d.attack_prev = attack;
            regs_d.dmg  = hurt_now && state_q != DEFEND;
            regs_d.blk  = hurt_now && state_q == DEFEND;
            regs_d.hit  = !hurt_now && state_q == ATTACK && regs_q.cnt == HIT_FRAME - 6'd1;
            regs_d.cnt  = (busy && !hurt_now && !last) ? regs_q.cnt + 6'd1 : 6'd0;
            regs_d.cool = (state_q == ATTACK && state_d != ATTACK) ? COOLDOWN_FRAMES
                        : (!busy && regs_q.cool != 6'd0) ? regs_q.cool - 6'd1 : regs_q.cool;
            if (state_d != state_q) begin
                regs_d.anim = 3'd0;
                regs_d.div  = 4'd0;
            end else if (regs_q.div == ANIM_DIV - 4'd1) begin
                regs_d.div  = 4'd0;
                regs_d.anim = (busy && regs_q.anim == 3'd7) ? 3'd7 : regs_q.anim + 3'd1;
            end else regs_d.div = regs_q.div + 4'd1;
            if (state_d == WALK) begin
                regs_d.facing = move_r;
                regs_d.pos_x  = move_r ? (hi_clamp ? X_MAX : regs_q.pos_x + STEP)
                                       : (lo_clamp ? X_MIN : regs_q.pos_x - STEP);
            end
        end
        if (io.restart) regs_d = RST;
    end

    assign io.pos_x         = regs_q.pos_x;
    assign io.facing        = regs_q.facing;
    assign io.state         = state_q;
    assign io.anim_frame    = regs_q.anim;
    assign io.hit_pulse     = regs_q.hit;
    assign io.damage_pulse  = regs_q.dmg;
    assign io.blocked_pulse = regs_q.blk;
endmodule

// File: tb/tb_character_action_fsm.sv
// tb_character_action_fsm: directed stimulus with a frame-level behavioural model checked every Clk.
module tb_character_action_fsm;
    localparam int S_IDLE = 0, S_WALK = 1, S_ATK = 2, S_DEF = 3, S_HURT = 4;

    logic Clk = 1'b0;
    logic Reset;
    int   n_cmp = 0, n_bad = 0;
    int   m_pos, m_face, m_state, m_anim, m_hit, m_dmg, m_blk;
    int   m_hpend, m_aprev, m_cool, m_phase, m_age;

    character_action_fsm_if io();
    character_action_fsm dut (.Clk(Clk), .Reset(Reset), .io(io));

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_init();
        m_pos = 120; m_face = 1; m_state = S_IDLE; m_anim = 0;
        m_hit = 0; m_dmg = 0; m_blk = 0;
        m_hpend = 0; m_aprev = 0; m_cool = 0; m_phase = 0; m_age = 0;
    endtask

    // Frame-level rules: phase counts ticks since an attack/hurt began, age counts ticks in the state.
    task automatic model_clock();
        int  ns;
        bit  hn, rise, free;
        hn = (m_hpend != 0) || io.hurt;
        m_hit = 0; m_dmg = 0; m_blk = 0;
        if (io.restart) begin
            model_init();
            return;
        end
        if (!(io.frame_tick && io.enable)) begin
            m_hpend = int'(hn);
            return;
        end
        m_hpend = 0;
        rise = io.attack && (m_aprev == 0);
        m_aprev = int'(io.attack);
        free = !(m_state == S_ATK || m_state == S_HURT);
        ns = m_state;
        if (hn && m_state == S_DEF) m_blk = 1;
        else if (hn) begin
            m_dmg = 1;
            if (m_state == S_ATK) m_cool = 12;
            ns = S_HURT;
            m_phase = 0;
        end else if (!free) begin
            m_phase++;
            if (m_state == S_ATK && m_phase == 9) m_hit = 1;
            if (m_phase == ((m_state == S_ATK) ? 18 : 15)) begin
                if (m_state == S_ATK) m_cool = 12;
                ns = S_IDLE;
            end
        end else if (rise && m_cool == 0) begin
            ns = S_ATK;
            m_phase = 0;
        end else if (io.defense) ns = S_DEF;
        else if (io.move_l != io.move_r) begin
            ns = S_WALK;
            m_face = int'(io.move_r);
            m_pos = io.move_r ? ((m_pos + 4 > 575) ? 575 : m_pos + 4) : ((m_pos - 4 < 0) ? 0 : m_pos - 4);
        end else ns = S_IDLE;
        if (free && m_cool > 0) m_cool--;
        m_age = (ns != m_state) ? 0 : m_age + 1;
        m_state = ns;
        m_anim = (ns == S_ATK || ns == S_HURT) ? ((m_age / 6 > 7) ? 7 : m_age / 6) : (m_age / 6) % 8;
    endtask

    task automatic compare();
        chk("pos_x", int'(io.pos_x), m_pos);
        chk("facing", int'(io.facing), m_face);
        chk("state", int'(io.state), m_state);
        chk("anim_frame", int'(io.anim_frame), m_anim);
        chk("hit_pulse", int'(io.hit_pulse), m_hit);
        chk("damage_pulse", int'(io.damage_pulse), m_dmg);
        chk("blocked_pulse", int'(io.blocked_pulse), m_blk);
    endtask

    task automatic cyc();
        @(posedge Clk);
        if (Reset) model_init();
        else model_clock();
        @(negedge Clk);
        compare();
    endtask

    // Keys change only right after a tick, so they are stable 3 Clk before the next one.
    task automatic tick_h(input bit h);
        io.frame_tick = 1'b0;
        repeat (3) cyc();
        io.frame_tick = 1'b1;
        io.hurt = h;
        cyc();
        io.hurt = 1'b0;
        io.frame_tick = 1'b0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick_h(1'b0);
    endtask

    task automatic pulse_hurt();
        io.hurt = 1'b1;
        cyc();
        io.hurt = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        io.frame_tick = 0; io.enable = 1; io.restart = 0;
        io.move_l = 0; io.move_r = 0; io.attack = 0; io.defense = 0; io.hurt = 0;
        model_init();
        cyc(); cyc();
        chk("rst_pos", int'(io.pos_x), 120);
        chk("rst_state", int'(io.state), 0);
        chk("rst_facing", int'(io.facing), 1);
        chk("rst_anim", int'(io.anim_frame), 0);
        Reset = 1'b0;

        io.move_r = 1; tick_n(20);
        chk("walk_pos", int'(io.pos_x), 200);
        chk("walk_pos_model", m_pos, 200);
        chk("walk_state", int'(io.state), 1);
        chk("walk_anim", int'(io.anim_frame), 3);
        chk("walk_anim_model", m_anim, 3);
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_pos", int'(io.pos_x), 120);
        chk("async_rst_state", int'(io.state), 0);
        chk("async_rst_facing", int'(io.facing), 1);
        cyc();
        Reset = 1'b0;

        tick_n(113);
        chk("right_572", int'(io.pos_x), 572);
        tick_n(87);
        chk("right_clamp", int'(io.pos_x), 575);
        chk("right_clamp_model", m_pos, 575);
        chk("right_anim", int'(io.anim_frame), 1);
        io.move_l = 1; tick_n(1);
        chk("both_state", int'(io.state), 0);
        chk("both_pos", int'(io.pos_x), 575);
        chk("both_facing", int'(io.facing), 1);

        io.move_l = 0; io.move_r = 0;
        io.restart = 1; cyc(); io.restart = 0;
        chk("restart_pos", int'(io.pos_x), 120);
        io.move_l = 1; tick_n(35);
        chk("left_clamp", int'(io.pos_x), 0);
        chk("left_facing", int'(io.facing), 0);
        io.move_l = 0; tick_n(1);
        chk("left_idle", int'(io.state), 0);

        io.attack = 1; tick_n(1);
        chk("atk_T_state", int'(io.state), 2);
        io.attack = 0; tick_n(8);
        chk("atk_T8_nohit", int'(io.hit_pulse), 0);
        tick_n(1);
        chk("atk_T9_hit", int'(io.hit_pulse), 1);
        chk("atk_T9_hit_model", m_hit, 1);
        chk("atk_T9_anim", int'(io.anim_frame), 1);
        tick_n(8);
        chk("atk_T17_state", int'(io.state), 2);
        tick_n(1);
        chk("atk_T18_idle", int'(io.state), 0);
        tick_n(1);
        io.attack = 1; tick_n(1);
        chk("atk_T20_refused", int'(io.state), 0);
        io.attack = 0; tick_n(11);
        io.attack = 1; tick_n(1);
        chk("atk_T32_accepted", int'(io.state), 2);
        io.attack = 0; tick_n(18);
        chk("atk2_done", int'(io.state), 0);
        tick_n(13);

        io.attack = 1; tick_n(1);
        io.attack = 0; tick_n(5);
        pulse_hurt();
        tick_n(1);
        chk("abort_damage", int'(io.damage_pulse), 1);
        chk("abort_state", int'(io.state), 4);
        tick_n(14);
        chk("hurt_14_state", int'(io.state), 4);
        tick_n(1);
        chk("hurt_exit_idle", int'(io.state), 0);
        io.attack = 1; tick_n(1);
        chk("post_hurt_cooldown", int'(io.state), 0);
        io.attack = 0;

        io.defense = 1; tick_n(1);
        chk("def_state", int'(io.state), 3);
        pulse_hurt();
        tick_n(1);
        chk("def_blocked", int'(io.blocked_pulse), 1);
        chk("def_no_damage", int'(io.damage_pulse), 0);
        chk("def_stays", int'(io.state), 3);
        tick_h(1'b1);
        chk("def_blocked_ontick", int'(io.blocked_pulse), 1);
        io.defense = 0; tick_n(1);
        chk("def_release", int'(io.state), 0);
        tick_h(1'b1);
        chk("idle_hurt_ontick", int'(io.damage_pulse), 1);
        tick_n(3);
        tick_h(1'b1);
        chk("hurt_restart_dmg", int'(io.damage_pulse), 1);
        tick_n(14);
        chk("hurt_restart_hold", int'(io.state), 4);
        tick_n(1);
        chk("hurt_restart_exit", int'(io.state), 0);
        tick_n(12);

        io.attack = 1; tick_n(1);
        io.attack = 0; tick_n(4);
        io.enable = 0; io.move_r = 1; tick_n(50);
        chk("frozen_state", int'(io.state), 2);
        chk("frozen_pos", int'(io.pos_x), 0);
        io.move_r = 0; io.enable = 1; tick_n(4);
        chk("resume_nohit", int'(io.hit_pulse), 0);
        tick_n(1);
        chk("resume_hit", int'(io.hit_pulse), 1);
        tick_n(9);
        chk("resume_done", int'(io.state), 0);

        io.enable = 0; pulse_hurt(); tick_n(3);
        io.enable = 1; tick_n(1);
        chk("latched_hurt_dmg", int'(io.damage_pulse), 1);
        chk("latched_hurt_state", int'(io.state), 4);
        tick_n(15);
        chk("latched_hurt_exit", int'(io.state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
